// File: rtl/sram_arbiter_if.sv
// Requester and SRAM-controller signal bundle for sram_arbiter.
// slave = arbiter side, master = requesters plus SRAM controller side.
interface sram_arbiter_if;
    logic        M0_req;
    logic        M1_req;
    logic        M0_we_n;
    logic        M1_we_n;
    logic [17:0] M0_address;
    logic [17:0] M1_address;
    logic [15:0] M0_write_data;
    logic [15:0] M1_write_data;
    logic        M0_gnt;
    logic        M1_gnt;
    logic        M0_rvalid;
    logic        M1_rvalid;
    logic [15:0] M_read_data;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;

    modport slave (
        input  M0_req, M1_req, M0_we_n, M1_we_n,
        input  M0_address, M1_address,
        input  M0_write_data, M1_write_data,
        input  SRAM_read_data,
        output M0_gnt, M1_gnt, M0_rvalid, M1_rvalid,
        output M_read_data,
        output SRAM_address, SRAM_write_data, SRAM_we_n
    );

    modport master (
        output M0_req, M1_req, M0_we_n, M1_we_n,
        output M0_address, M1_address,
        output M0_write_data, M1_write_data,
        output SRAM_read_data,
        input  M0_gnt, M1_gnt, M0_rvalid, M1_rvalid,
        input  M_read_data,
        input  SRAM_address, SRAM_write_data, SRAM_we_n
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester SRAM arbiter: Moore grant FSM, tenure limit, tagged read return.
// Option macro SRAM_ARB_FIXED_PRIORITY_EN: M0 wins ties and is never preempted.
module sram_arbiter #(
    parameter int READ_LATENCY = 2,
    parameter int BURST_MAX    = 64
) (
    input  logic          Clock_50,
    input  logic          Resetn,
    sram_arbiter_if.slave bus
);
    localparam int CW = $clog2(BURST_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWN0,
        S_OWN1
    } state_t;

    state_t        state;
    logic          last1;
    logic [CW-1:0] tenure;
    logic [1:0]    tag_pipe [READ_LATENCY];
    logic [1:0]    rvalid_q;

    logic acc0;
    logic acc1;
    logic burst_done;
    logic tie_m1;
    logic pre0;
    logic pre1;

    assign bus.M0_gnt = (state == S_OWN0);
    assign bus.M1_gnt = (state == S_OWN1);
    assign acc0 = bus.M0_gnt & bus.M0_req;
    assign acc1 = bus.M1_gnt & bus.M1_req;

    // The acceptance happening now is the BURST_MAX-th of this tenure
    assign burst_done = (tenure >= CW'(BURST_MAX - 1));

`ifdef SRAM_ARB_FIXED_PRIORITY_EN
    assign tie_m1 = 1'b0;
    assign pre0   = 1'b0;
    assign pre1   = 1'b1;
`else
    assign tie_m1 = ~last1;
    assign pre0   = 1'b1;
    assign pre1   = 1'b1;
`endif

    assign bus.M0_rvalid   = rvalid_q[0];
    assign bus.M1_rvalid   = rvalid_q[1];
    assign bus.M_read_data = (|rvalid_q) ? bus.SRAM_read_data : 16'h0;

    // Ownership FSM with round-robin memory and tenure counter
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state  <= S_IDLE;
            last1  <= 1'b1;
            tenure <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    tenure <= '0;
                    if (bus.M0_req && bus.M1_req) begin
                        state <= tie_m1 ? S_OWN1 : S_OWN0;
                        last1 <= tie_m1;
                    end else if (bus.M0_req) begin
                        state <= S_OWN0;
                        last1 <= 1'b0;
                    end else if (bus.M1_req) begin
                        state <= S_OWN1;
                        last1 <= 1'b1;
                    end
                end
                S_OWN0: begin
                    if (!bus.M0_req) begin
                        tenure <= '0;
                        if (bus.M1_req) begin
                            state <= S_OWN1;
                            last1 <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (pre0 && burst_done && bus.M1_req) begin
                        tenure <= '0;
                        state  <= S_OWN1;
                        last1  <= 1'b1;
                    end else if (tenure != CW'(BURST_MAX)) begin
                        tenure <= tenure + 1'b1;
                    end
                end
                S_OWN1: begin
                    if (!bus.M1_req) begin
                        tenure <= '0;
                        if (bus.M0_req) begin
                            state <= S_OWN0;
                            last1 <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (pre1 && burst_done && bus.M0_req) begin
                        tenure <= '0;
                        state  <= S_OWN0;
                        last1  <= 1'b0;
                    end else if (tenure != CW'(BURST_MAX)) begin
                        tenure <= tenure + 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    tenure <= '0;
                end
            endcase
        end
    end

    // Launch the accepted transaction to the SRAM controller
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            bus.SRAM_we_n       <= 1'b1;
            bus.SRAM_address    <= '0;
            bus.SRAM_write_data <= '0;
        end else if (acc0) begin
            bus.SRAM_we_n       <= bus.M0_we_n;
            bus.SRAM_address    <= bus.M0_address;
            bus.SRAM_write_data <= bus.M0_write_data;
        end else if (acc1) begin
            bus.SRAM_we_n       <= bus.M1_we_n;
            bus.SRAM_address    <= bus.M1_address;
            bus.SRAM_write_data <= bus.M1_write_data;
        end else begin
            bus.SRAM_we_n       <= 1'b1;
            bus.SRAM_write_data <= '0;
        end
    end

    // Owner tags follow each read so returns reach the original requester
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_pipe[i] <= 2'b00;
            end
            rvalid_q <= 2'b00;
        end else begin
            tag_pipe[0] <= {acc1 & bus.M1_we_n, acc0 & bus.M0_we_n};
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            rvalid_q <= tag_pipe[READ_LATENCY-1];
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus random
// traffic against a transaction-level model and an SRAM behavioural model.
module tb_sram_arbiter;
    localparam int RL = 2;
    localparam int BM = 64;
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic Clock_50 = 1'b0;
    logic Resetn   = 1'b0;

    sram_arbiter_if bus ();

    sram_arbiter #(
        .READ_LATENCY(RL),
        .BURST_MAX   (BM)
    ) dut (
        .Clock_50(Clock_50),
        .Resetn  (Resetn),
        .bus     (bus)
    );

    always #5 Clock_50 = ~Clock_50;

    typedef struct packed {
        logic        we_n;
        logic [17:0] addr;
        logic [15:0] data;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];

    int          owner;
    int          last;
    int          served;
    logic        e_we;
    logic [17:0] e_addr;
    logic [15:0] e_wd;
    bit   [1:0]  e_rv   [int];
    logic [15:0] e_rd   [int];
    logic [15:0] mdl_mem[int];
    logic [15:0] sram_mem[int];
    logic [15:0] rd_hist[int];
    int cyc;
    int total;
    int bad;

    int   n_acc0;
    bit   m1_seen;
    int   n_rv1;
    int   n_rv_any;
    int   n_we0;
    int   n_rv0_own1;
    int   n_gap;
    bit   gap_mon;
    logic [15:0] last_rd0;

    function automatic logic [15:0] init_val(logic [17:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] mdl_get(logic [17:0] a);
        if (mdl_mem.exists(int'(a))) return mdl_mem[int'(a)];
        return init_val(a);
    endfunction

    function automatic logic [15:0] sram_get(logic [17:0] a);
        if (sram_mem.exists(int'(a))) return sram_mem[int'(a)];
        return init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h cyc=%0d",
                   tag, obs, exp, cyc);
        end
    endtask

    task automatic mdl_reset();
        owner  = -1;
        last   = 1;
        served = 0;
        e_we   = 1'b1;
        e_addr = '0;
        e_wd   = '0;
        e_rv.delete();
        e_rd.delete();
    endtask

    task automatic drive();
        bus.M0_req = (q0.size() > 0);
        bus.M1_req = (q1.size() > 0);
        if (q0.size() > 0) begin
            bus.M0_we_n       = q0[0].we_n;
            bus.M0_address    = q0[0].addr;
            bus.M0_write_data = q0[0].data;
        end
        if (q1.size() > 0) begin
            bus.M1_we_n       = q1[0].we_n;
            bus.M1_address    = q1[0].addr;
            bus.M1_write_data = q1[0].data;
        end
    endtask

    // Transaction-level prediction of what the coming edge does
    task automatic model_pre();
        bit   r0;
        bit   r1;
        bit   acc;
        bit   own_rq;
        bit   oth_rq;
        int   m;
        int   nxt;
        txn_t t;
        r0 = bus.M0_req;
        r1 = bus.M1_req;
        if (!m1_seen && bus.M1_gnt === 1'b1) m1_seen = 1'b1;
        if (!m1_seen && bus.M0_req && bus.M0_gnt === 1'b1) n_acc0++;
        if (!Resetn) begin
            mdl_reset();
            return;
        end
        acc = 1'b0;
        m   = 0;
        t   = '0;
        if (owner == 0 && r0) begin
            acc = 1'b1;
            t   = q0.pop_front();
            m   = 0;
        end else if (owner == 1 && r1) begin
            acc = 1'b1;
            t   = q1.pop_front();
            m   = 1;
        end
        e_we = 1'b1;
        e_wd = '0;
        if (acc) begin
            e_we   = t.we_n;
            e_addr = t.addr;
            e_wd   = t.data;
            if (t.we_n) begin
                e_rv[cyc + 1 + RL] = (m == 0) ? 2'b01 : 2'b10;
                e_rd[cyc + 1 + RL] = mdl_get(t.addr);
            end else begin
                mdl_mem[int'(t.addr)] = t.data;
            end
            served++;
        end
        nxt = owner;
        if (owner < 0) begin
            if (r0 && r1) nxt = (FIXED || last == 1) ? 0 : 1;
            else if (r0) nxt = 0;
            else if (r1) nxt = 1;
        end else begin
            own_rq = (owner == 0) ? r0 : r1;
            oth_rq = (owner == 0) ? r1 : r0;
            if (!own_rq) begin
                nxt = oth_rq ? 1 - owner : -1;
            end else if (served >= BM && oth_rq &&
                         !(FIXED && owner == 0)) begin
                nxt = 1 - owner;
            end
        end
        if (nxt != owner) begin
            served = 0;
            if (nxt >= 0) last = nxt;
        end
        owner = nxt;
    endtask

    task automatic check_cycle();
        bit [1:0] xr;
        xr = e_rv.exists(cyc) ? e_rv[cyc] : 2'b00;
        chk("gnt0", 32'(bus.M0_gnt), 32'(owner == 0));
        chk("gnt1", 32'(bus.M1_gnt), 32'(owner == 1));
        chk("we_n", 32'(bus.SRAM_we_n), 32'(e_we));
        chk("addr", 32'(bus.SRAM_address), 32'(e_addr));
        chk("wdata", 32'(bus.SRAM_write_data), 32'(e_wd));
        chk("rvalid0", 32'(bus.M0_rvalid), 32'(xr[0]));
        chk("rvalid1", 32'(bus.M1_rvalid), 32'(xr[1]));
        if (xr != 2'b00) chk("rdata", 32'(bus.M_read_data), 32'(e_rd[cyc]));
        if (bus.M1_rvalid === 1'b1) n_rv1++;
        if (bus.M0_rvalid === 1'b1 || bus.M1_rvalid === 1'b1) n_rv_any++;
        if (bus.SRAM_we_n === 1'b0) n_we0++;
        if (bus.M0_rvalid === 1'b1 && bus.M1_gnt === 1'b1) n_rv0_own1++;
        if (bus.M0_rvalid === 1'b1) last_rd0 = bus.M_read_data;
        if (gap_mon && bus.M0_gnt !== 1'b1 && bus.M1_gnt !== 1'b1 &&
            (q0.size() > 0 || q1.size() > 0)) n_gap++;
    endtask

    task automatic tick();
        drive();
        model_pre();
        @(posedge Clock_50);
        #1;
        cyc++;
        rd_hist[cyc] = sram_get(bus.SRAM_address);
        if (bus.SRAM_we_n === 1'b0)
            sram_mem[int'(bus.SRAM_address)] = bus.SRAM_write_data;
        bus.SRAM_read_data = rd_hist.exists(cyc - RL) ? rd_hist[cyc - RL]
                                                      : 16'h0;
        #1;
        check_cycle();
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        mdl_reset();
        repeat (2) tick();
        Resetn = 1'b1;
    endtask

    function automatic txn_t rd_txn(logic [17:0] a);
        txn_t t;
        t.we_n = 1'b1;
        t.addr = a;
        t.data = 16'($urandom);
        return t;
    endfunction

    function automatic txn_t rnd_txn();
        txn_t t;
        t.we_n = ($urandom_range(0, 2) != 0);
        t.addr = 18'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) t.addr = t.addr | 18'h3FFF0;
        t.data = 16'($urandom);
        return t;
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        n_acc0 = 0;
        m1_seen = 1'b0;
        n_rv1 = 0;
        n_rv_any = 0;
        n_we0 = 0;
        n_rv0_own1 = 0;
        n_gap = 0;
        gap_mon = 1'b0;
        last_rd0 = '0;
        bus.M0_req = 1'b0;
        bus.M1_req = 1'b0;
        bus.M0_we_n = 1'b1;
        bus.M1_we_n = 1'b1;
        bus.M0_address = '0;
        bus.M1_address = '0;
        bus.M0_write_data = '0;
        bus.M1_write_data = '0;
        bus.SRAM_read_data = '0;
        mdl_reset();

        // reset state, held over several cycles
        repeat (3) tick();
        Resetn = 1'b1;

        // single read by M0
        sram_mem[32'h100] = 16'hABCD;
        mdl_mem[32'h100]  = 16'hABCD;
        q0.push_back(rd_txn(18'h00100));
        n_rv1 = 0;
        tick();
        chk("s1_gnt_c1", 32'(bus.M0_gnt), 32'd1);
        tick();
        chk("s1_addr_c2", 32'(bus.SRAM_address), 32'h00100);
        tick();
        chk("s1_rv_c3", 32'(bus.M0_rvalid), 32'd0);
        tick();
        chk("s1_rv_c4", 32'(bus.M0_rvalid), 32'd1);
        chk("s1_data_c4", 32'(bus.M_read_data), 32'hABCD);
        repeat (3) tick();
        chk("s1_no_rv1", 32'(n_rv1), 32'd0);

        // simultaneous requests from reset
        do_reset();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(rd_txn(18'(16 + i)));
            q1.push_back(rd_txn(18'(32 + i)));
        end
        n_gap = 0;
        tick();
        gap_mon = 1'b1;
        chk("tie_first_m0", 32'(bus.M0_gnt), 32'd1);
        repeat (12) tick();
        gap_mon = 1'b0;
        chk("handover_gap", 32'(n_gap), 32'd0);
        q0.push_back(rd_txn(18'h00040));
        repeat (4) tick();
        q0.push_back(rd_txn(18'h00041));
        q1.push_back(rd_txn(18'h00042));
        tick();
        chk("tie_after_m0", 32'(bus.M1_gnt), FIXED ? 32'd0 : 32'd1);
        repeat (10) tick();

        // tenure limit with M1 waiting
        do_reset();
        for (int i = 0; i < 70; i++) q0.push_back(rd_txn(18'(i)));
        q1.push_back(rd_txn(18'h01000));
        q1.push_back(rd_txn(18'h01001));
        n_acc0  = 0;
        m1_seen = 1'b0;
        repeat (100) tick();
        chk("burst_acc0", 32'(n_acc0), FIXED ? 32'd70 : 32'd64);
        chk("burst_m1_seen", 32'(m1_seen), 32'd1);

        // M1 write at top address then M0 read-back
        begin
            txn_t w;
            w.we_n = 1'b0;
            w.addr = 18'h3FFFF;
            w.data = 16'h1234;
            q1.push_back(w);
        end
        n_we0 = 0;
        n_rv1 = 0;
        repeat (5) tick();
        q0.push_back(rd_txn(18'h3FFFF));
        repeat (8) tick();
        chk("wr_once", 32'(n_we0), 32'd1);
        chk("wr_rd_data", 32'(last_rd0), 32'h1234);
        chk("wr_no_rv1", 32'(n_rv1), 32'd0);

        // ownership switch with two M0 reads in flight
        q0.push_back(rd_txn(18'h00200));
        q0.push_back(rd_txn(18'h00201));
        n_rv0_own1 = 0;
        tick();
        for (int i = 0; i < 4; i++) q1.push_back(rd_txn(18'(18'h00300 + i)));
        repeat (12) tick();
        chk("inflight_rv0", 32'(n_rv0_own1), 32'd2);

        // reset with a read in flight
        q0.push_back(rd_txn(18'h00123));
        repeat (3) tick();
        #2;
        Resetn = 1'b0;
        #1;
        mdl_reset();
        chk("rst_gnt0", 32'(bus.M0_gnt), 32'd0);
        chk("rst_gnt1", 32'(bus.M1_gnt), 32'd0);
        chk("rst_rv0", 32'(bus.M0_rvalid), 32'd0);
        chk("rst_rv1", 32'(bus.M1_rvalid), 32'd0);
        chk("rst_rdata", 32'(bus.M_read_data), 32'd0);
        chk("rst_we_n", 32'(bus.SRAM_we_n), 32'd1);
        chk("rst_addr", 32'(bus.SRAM_address), 32'd0);
        chk("rst_wdata", 32'(bus.SRAM_write_data), 32'd0);
        repeat (2) tick();
        Resetn = 1'b1;
        n_rv_any = 0;
        repeat (6) tick();
        chk("rst_no_rv", 32'(n_rv_any), 32'd0);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0 && q0.size() < 4)
                q0.push_back(rnd_txn());
            if ($urandom_range(0, 2) == 0 && q1.size() < 4)
                q1.push_back(rnd_txn());
            tick();
        end
        for (int i = 0; i < 200 && (q0.size() > 0 || q1.size() > 0); i++)
            tick();
        chk("drain", 32'(q0.size() + q1.size()), 32'd0);
        repeat (RL + 3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter READ_LATENCY, default 2: clock cycles from registered SRAM_address launch to valid SRAM_read_data.
REQ-002 The block SHALL have parameter BURST_MAX, default 64: maximum accepted transactions per grant tenure while the other requester waits.
REQ-003 The block SHALL have port Clock_50, input, 1 bit: the single clock, all logic on its rising edge.
REQ-004 The block SHALL have port Resetn, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have ports M0_req, M1_req, input, 1 bit each: requester holds high while it has transactions to issue.
REQ-006 The block SHALL have ports M0_we_n, M1_we_n, input, 1 bit each: 0 = write, 1 = read.
REQ-007 The block SHALL have ports M0_address, M1_address, input, 18 bits each: word address.
REQ-008 The block SHALL have ports M0_write_data, M1_write_data, input, 16 bits each: write data.
REQ-009 The block SHALL have ports M0_gnt, M1_gnt, output, 1 bit each: ownership; a transaction is accepted in any cycle with Mx_req and Mx_gnt both high.
REQ-010 The block SHALL have ports M0_rvalid, M1_rvalid, output, 1 bit each: one-cycle strobe qualifying returned read data.
REQ-011 The block SHALL have port M_read_data, output, 16 bits: read data shared by both requesters, valid only with an rvalid strobe.
REQ-012 The block SHALL have ports SRAM_address (18 bits), SRAM_write_data (16 bits) and SRAM_we_n (1 bit), all outputs: registered drive to the SRAM controller.
REQ-013 The block SHALL have port SRAM_read_data, input, 16 bits: read data from the SRAM controller.

Function
REQ-014 The block SHALL use a three-state FSM with states S_IDLE, S_OWN0 and S_OWN1, and SHALL derive Mx_gnt only from the state register (Moore; M0_gnt high only in S_OWN0, M1_gnt high only in S_OWN1).
REQ-015 In S_IDLE with exactly one request high, the FSM SHALL move to that requester's OWN state; S_IDLE itself issues no grant, so first-access latency is one cycle.
REQ-016 In S_IDLE with both requests high, the FSM SHALL grant the requester that was not the last owner (round-robin).
REQ-017 In S_OWNx with Mx_req low, the FSM SHALL move directly to the other OWN state if the other req is high, else to S_IDLE; no dead cycle on handover.
REQ-018 A tenure counter SHALL count accepted transactions in the current OWN state, clear on every state change, and force a move to the other OWN state after the BURST_MAX-th acceptance when the other req is high; with the other req low, the counter SHALL saturate and ownership SHALL continue.
REQ-019 Each accepted transaction SHALL appear on SRAM_address, SRAM_write_data and SRAM_we_n on the next cycle; with no acceptance, SRAM_we_n SHALL be 1, SRAM_address SHALL hold its last value, and SRAM_write_data SHALL be 0.
REQ-020 Each accepted read SHALL push an owner tag into a READ_LATENCY-deep pipeline, and the matching Mx_rvalid SHALL pulse exactly READ_LATENCY cycles after the SRAM_address launch cycle, with M_read_data equal to SRAM_read_data in that cycle.
REQ-021 In-flight read returns SHALL complete to their original requester regardless of later ownership changes, and back-to-back reads SHALL give back-to-back rvalid pulses in issue order.
REQ-022 Writes SHALL generate no rvalid.

Reset
REQ-023 On Resetn low, asynchronously, the block SHALL set: state S_IDLE; both gnt 0; both rvalid 0; M_read_data 0; SRAM_we_n 1; SRAM_address 0; SRAM_write_data 0; tenure counter 0; all tag pipeline entries empty; last owner M1, so M0 wins the first tie.
REQ-024 A reset during in-flight reads SHALL discard them, and no rvalid SHALL be asserted for them after reset release.

Configuration
REQ-025 With macro SRAM_ARB_FIXED_PRIORITY_EN defined, ties in S_IDLE SHALL always go to M0, the BURST_MAX preemption SHALL apply only to S_OWN1, and M0 SHALL never be preempted.
REQ-026 Without SRAM_ARB_FIXED_PRIORITY_EN, the round-robin tie-break and symmetric preemption of REQ-016 and REQ-018 SHALL apply.

Verification
REQ-027 Single read: M0 reads address 18'h00100 holding 16'hABCD -> M0_gnt high at cycle 1, SRAM_address = 18'h00100 at cycle 2, M0_rvalid with 16'hABCD at cycle 4, M1_rvalid stays 0.
REQ-028 Simultaneous requests from reset, 3 reads each -> M0 is served first and M1 takes over with no idle cycle; next tie goes to M1.
REQ-029 M0 streams 70 reads while M1_req is high -> exactly 64 M0 acceptances, then M1_gnt high; the same stimulus with SRAM_ARB_FIXED_PRIORITY_EN defined -> M0 holds ownership for all 70.
REQ-030 M1 write of 16'h1234 to 18'h3FFFF, then M0 read of 18'h3FFFF -> SRAM_we_n 0 for one cycle, M0_rvalid returns 16'h1234, no M1_rvalid.
REQ-031 Ownership switch with 2 M0 reads in flight -> both M0_rvalid pulses arrive at the correct cycles during S_OWN1.
REQ-032 Resetn low one cycle after a read launch -> no rvalid after reset release, and all outputs at their REQ-023 values.
